// File: rtl/alu_ctrl_unit.sv
// EX-stage ALU control register plus an iterative mul/div sequencer that owns HI/LO.
// HI/LO-class instructions stall while the sequencer is busy; all other instructions keep flowing.
module alu_ctrl_unit #(
  parameter int         DATA_W   = 32,
  parameter int         CTRL_W   = 6,
  parameter logic [5:0] LW_OP    = 6'h23,
  parameter logic [5:0] SW_OP    = 6'h2B,
  parameter logic [5:0] ADD_FUNC = 6'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              ex_stall,
  output logic              out_valid,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              busy,
  output logic              stall_req,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic [5:0]        dec6;
  logic [CTRL_W-1:0] dec;
  logic              is_r, is_muldiv, is_mt, hilo, accept, start;

  // sequencer datapath: acc_hi/acc_lo are product halves (mul) or remainder/quotient (div)
  logic [DATA_W-1:0] acc_hi, acc_lo, opnd, rs_raw;
  logic              op_div, neg_q, neg_r, div_zero;

  logic              sgn, a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   sum, shl, diff;
  logic [DATA_W-1:0] hi_step, lo_step, hi_res, lo_res;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    dec6 = op;
    if (op == 6'h00) dec6 = func;
    else if (op == LW_OP || op == SW_OP) dec6 = ADD_FUNC;
    dec = '0;
    dec[5:0] = dec6;
  end

  // 0x18-0x1B are MULT/MULTU/DIV/DIVU, 0x10-0x13 are MFHI/MTHI/MFLO/MTLO
  assign is_r      = (op == 6'h00);
  assign is_muldiv = is_r && (func[5:2] == 4'b0110);
  assign is_mt     = is_r && (func == 6'h11 || func == 6'h13);
  assign hilo      = is_r && (func[5:2] == 4'b0110 || func[5:2] == 4'b0100);
  assign stall_req = in_valid & busy & hilo;
  assign accept    = in_valid & ~ex_stall & ~stall_req;
  assign start     = accept & is_muldiv & (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_ctrl  <= '0;
    end else if (!ex_stall) begin
      out_valid <= accept;
      alu_ctrl  <= dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == RUN && state_nxt == RUN) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sgn   = ~func[0];
    a_neg = sgn & rs_val[DATA_W-1];
    b_neg = sgn & rt_val[DATA_W-1];
    a_mag = a_neg ? -rs_val : rs_val;
    b_mag = b_neg ? -rt_val : rt_val;

    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shl  = {acc_hi, acc_lo[DATA_W-1]};
    diff = shl - {1'b0, opnd};
    if (!op_div) begin
      {hi_step, lo_step} = {sum, acc_lo[DATA_W-1:1]};
    end else if (!diff[DATA_W]) begin
      hi_step = diff[DATA_W-1:0];
      lo_step = {acc_lo[DATA_W-2:0], 1'b1};
    end else begin
      hi_step = shl[DATA_W-1:0];
      lo_step = {acc_lo[DATA_W-2:0], 1'b0};
    end

    // most-negative / -1 needs no special case: magnitude quotient already equals the result bits
    prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (!op_div) begin
      {hi_res, lo_res} = prod;
    end else if (div_zero) begin
      hi_res = rs_raw;
      lo_res = '1;
    end else begin
      hi_res = neg_r ? -acc_hi : acc_hi;
      lo_res = neg_q ? -acc_lo : acc_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      rs_raw   <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      acc_hi   <= '0;
      acc_lo   <= func[1] ? a_mag : b_mag;
      opnd     <= func[1] ? b_mag : a_mag;
      rs_raw   <= rs_val;
      op_div   <= func[1];
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (rt_val == '0);
    end else if (state == RUN) begin
      acc_hi <= hi_step;
      acc_lo <= lo_step;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == DONE) begin
      hi <= hi_res;
      lo <= lo_res;
    end else if (accept && is_mt) begin
      if (func == 6'h11) hi <= rs_val;
      else               lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed bench for alu_ctrl_unit: decode, mul/div results, hazard stalls, ex_stall hold, reset abort.
module tb_alu_ctrl_unit;

  localparam int W = 32;

  logic          clk, rst_n, in_valid, ex_stall;
  logic [5:0]    op, func;
  logic [W-1:0]  rs_val, rt_val;
  logic          out_valid, busy, stall_req;
  logic [5:0]    alu_ctrl;
  logic [W-1:0]  hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  int nbusy = 0;

  alu_ctrl_unit #(.DATA_W(W), .CTRL_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .func(func),
    .rs_val(rs_val), .rt_val(rt_val), .ex_stall(ex_stall),
    .out_valid(out_valid), .alu_ctrl(alu_ctrl), .busy(busy), .stall_req(stall_req),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) nbusy++;
  endtask

  task automatic drive(input logic v, input logic [5:0] o, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = v; op = o; func = f; rs_val = a; rt_val = b;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (busy && g < 200) begin
      tick();
      g++;
    end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_muldiv(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    nbusy = 0;
    drive(1, 6'h00, f, a, b);
    tick();
    drive(0, 6'h00, 6'h00, 0, 0);
    wait_idle(tag);
    chk({tag, "_busy_cycles"}, nbusy, W + 1);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, g;
    // reset with junk on the inputs, including a HILO-class request
    rst_n = 1'b0; ex_stall = 1'b0;
    drive(1, 6'h00, 6'h12, 32'hDEADBEEF, 32'h12345678);
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall_req", stall_req, 0);
    drive(0, 6'h00, 6'h00, 0, 0);
    rst_n = 1'b1;
    tick();

    // decode
    drive(1, 6'h23, 6'h3F, 0, 0); tick();
    chk("dec_lw_ctrl", alu_ctrl, 6'h20);
    chk("dec_lw_valid", out_valid, 1);
    drive(1, 6'h0C, 6'h01, 0, 0); tick();
    chk("dec_andi", alu_ctrl, 6'h0C);
    drive(1, 6'h00, 6'h22, 0, 0); tick();
    chk("dec_sub", alu_ctrl, 6'h22);
    drive(1, 6'h2B, 6'h00, 0, 0); tick();
    chk("dec_sw", alu_ctrl, 6'h20);
    drive(0, 6'h00, 6'h22, 0, 0); tick();
    chk("dec_idle_valid", out_valid, 0);
    chk("dec_hilo_untouched", {hi, lo}, 0);

    // MTHI / MTLO
    drive(1, 6'h00, 6'h11, 32'h1234, 0); tick();
    chk("mthi", hi, 32'h1234);
    drive(1, 6'h00, 6'h13, 32'h5678, 0); tick();
    chk("mtlo", lo, 32'h5678);
    chk("mtlo_hi_kept", hi, 32'h1234);

    // MULT -3 * 7, hi/lo untouched while running
    nbusy = 0;
    drive(1, 6'h00, 6'h18, -3, 7); tick();
    drive(0, 6'h00, 6'h00, 0, 0);
    tick();
    chk("mult_hold_hi", hi, 32'h1234);
    wait_idle("mult");
    chk("mult_busy_cycles", nbusy, W + 1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    // DIV -7 / 2 with MFLO stalled and an ADD flowing past
    nbusy = 0;
    drive(1, 6'h00, 6'h1A, -7, 2); tick();
    drive(1, 6'h00, 6'h12, 0, 0); #1;
    chk("mflo_stall_req", stall_req, 1);
    tick();
    chk("mflo_no_valid", out_valid, 0);
    drive(1, 6'h00, 6'h20, 1, 2); #1;
    chk("add_no_stall", stall_req, 0);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_ctrl", alu_ctrl, 6'h20);
    drive(1, 6'h00, 6'h12, 0, 0);
    bad = 0; g = 0;
    while (busy && g < 200) begin
      tick();
      g++;
      if (out_valid) bad++;
    end
    chk("mflo_held_cycles", bad, 0);
    chk("div_idle", busy, 0);
    chk("div_busy_cycles", nbusy, W + 1);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("mflo_released", stall_req, 0);
    tick();
    chk("mflo_valid", out_valid, 1);
    chk("mflo_ctrl", alu_ctrl, 6'h12);
    drive(0, 6'h00, 6'h00, 0, 0);
    tick();

    // DIVU 7 / 0 with a 3-cycle ex_stall during RUN
    nbusy = 0;
    drive(1, 6'h00, 6'h1B, 7, 0); tick();
    drive(1, 6'h0D, 6'h00, 0, 0); tick();
    chk("ori_valid", out_valid, 1);
    chk("ori_ctrl", alu_ctrl, 6'h0D);
    ex_stall = 1'b1;
    drive(1, 6'h08, 6'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("exstall_valid_held", out_valid, 1);
      chk("exstall_ctrl_held", alu_ctrl, 6'h0D);
    end
    ex_stall = 1'b0;
    drive(0, 6'h00, 6'h00, 0, 0);
    tick();
    chk("exstall_release_valid", out_valid, 0);
    wait_idle("divu0");
    chk("divu0_busy_cycles", nbusy, W + 1);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'h7);

    // boundary cases
    do_muldiv("divmin", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    do_muldiv("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    do_muldiv("divu_big", 6'h1B, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF);

    // reset at RUN cycle 10 aborts without a HI/LO write
    drive(1, 6'h00, 6'h18, 9, 9); tick();
    drive(0, 6'h00, 6'h00, 0, 0);
    repeat (9) tick();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_out_valid", out_valid, 0);
    rst_n = 1'b1;
    tick();
    do_muldiv("multu_5x6", 6'h19, 5, 6, 32'h0, 32'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
